// File: rtl/dm_arbiter_if.sv
// Bundle of both requester ports and the data-memory side of the two-port DM arbiter.
// The arbiter takes the slave view; the requesters and the memory take the master view.
interface dm_arbiter_if #(
  parameter int AW = 32,
  parameter int DW = 32
);
  logic          REQ0;
  logic          LOCK0;
  logic          WE0;
  logic [AW-1:0] A0;
  logic [DW-1:0] WD0;
  logic          ACK0;
  logic [DW-1:0] RD0;

  logic          REQ1;
  logic          LOCK1;
  logic          WE1;
  logic [AW-1:0] A1;
  logic [DW-1:0] WD1;
  logic          ACK1;
  logic [DW-1:0] RD1;

  logic          DMWE;
  logic [AW-1:0] DMA;
  logic [DW-1:0] DMWD;
  logic [DW-1:0] DMRD;

  modport slave (
    input  REQ0, LOCK0, WE0, A0, WD0,
    input  REQ1, LOCK1, WE1, A1, WD1,
    input  DMRD,
    output ACK0, RD0, ACK1, RD1,
    output DMWE, DMA, DMWD
  );

  modport master (
    output REQ0, LOCK0, WE0, A0, WD0,
    output REQ1, LOCK1, WE1, A1, WD1,
    output DMRD,
    input  ACK0, RD0, ACK1, RD1,
    input  DMWE, DMA, DMWD
  );
endinterface

// File: rtl/dm_arbiter.sv
// Round-robin arbiter sharing the single-port data memory between the CPU (port 0) and DMA (port 1),
// with a bounded burst lock and zero-bubble hand-over; all outputs are combinational from the grant.
module dm_arbiter #(
  parameter int AW        = 32,
  parameter int DW        = 32,
  parameter int MAX_BURST = 4
) (
  input  logic         CLK,
  input  logic         RST,
  dm_arbiter_if.slave  bus
);

  localparam int              BCW  = $clog2(MAX_BURST) + 1;
  localparam logic [BCW-1:0]  BMAX = BCW'(MAX_BURST - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    G0   = 2'd1,
    G1   = 2'd2
  } state_t;

  state_t         r_state;
  state_t         w_state_nxt;
  logic           r_last;
  logic           w_last_nxt;
  logic [BCW-1:0] r_bcnt;
  logic [BCW-1:0] w_bcnt_nxt;

  logic           w_gnt1;
  logic           w_req_g;
  logic           w_lock_g;
  logic           w_we_g;
  logic           w_req_o;
  logic [AW-1:0]  w_a_g;
  logic [DW-1:0]  w_wd_g;

  // Granted-port view of the request bundle; only meaningful outside IDLE.
  always_comb begin
    w_gnt1   = (r_state == G1);
    w_req_g  = w_gnt1 ? bus.REQ1  : bus.REQ0;
    w_lock_g = w_gnt1 ? bus.LOCK1 : bus.LOCK0;
    w_we_g   = w_gnt1 ? bus.WE1   : bus.WE0;
    w_a_g    = w_gnt1 ? bus.A1    : bus.A0;
    w_wd_g   = w_gnt1 ? bus.WD1   : bus.WD0;
    w_req_o  = w_gnt1 ? bus.REQ0  : bus.REQ1;
  end

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    w_state_nxt = r_state;
    w_last_nxt  = r_last;
    w_bcnt_nxt  = r_bcnt;
    case (r_state)
      IDLE: begin
        w_bcnt_nxt = '0;
        if (bus.REQ0 && bus.REQ1) w_state_nxt = r_last ? G0 : G1;
        else if (bus.REQ0)        w_state_nxt = G0;
        else if (bus.REQ1)        w_state_nxt = G1;
      end
      G0, G1: begin
        if (w_req_g) w_last_nxt = w_gnt1;
        if (w_lock_g && w_req_g && (r_bcnt < BMAX)) begin
          w_bcnt_nxt = r_bcnt + BCW'(1);
        end else begin
          w_bcnt_nxt = '0;
          // The other port takes over directly, so contention never costs an idle cycle.
          if (w_req_o)       w_state_nxt = w_gnt1 ? G0 : G1;
          else if (!w_req_g) w_state_nxt = IDLE;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      r_state <= IDLE;
      r_last  <= 1'b1;
      r_bcnt  <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_last  <= w_last_nxt;
      r_bcnt  <= w_bcnt_nxt;
    end
  end

  // Reset drives the state to IDLE asynchronously, which zeroes every output at once.
  always_comb begin
    bus.ACK0 = 1'b0;
    bus.ACK1 = 1'b0;
    bus.RD0  = '0;
    bus.RD1  = '0;
    bus.DMWE = 1'b0;
    bus.DMA  = '0;
    bus.DMWD = '0;
    if (r_state != IDLE) begin
      bus.DMA  = w_a_g;
      bus.DMWD = w_wd_g;
      bus.DMWE = w_we_g & w_req_g;
      if (w_gnt1) begin
        bus.ACK1 = bus.REQ1;
        bus.RD1  = bus.REQ1 ? bus.DMRD : '0;
      end else begin
        bus.ACK0 = bus.REQ0;
        bus.RD0  = bus.REQ0 ? bus.DMRD : '0;
      end
    end
  end

endmodule

// File: tb/tb_dm_arbiter.sv
// Self-checking bench for dm_arbiter: a transaction-level owner/round-robin model plus a
// reference memory is compared against the DUT every cycle, alongside directed scenarios.
module tb_dm_arbiter;

  localparam int AW        = 32;
  localparam int DW        = 32;
  localparam int MAX_BURST = 4;

  logic CLK = 1'b0;
  logic RST = 1'b0;
  always #5 CLK = ~CLK;

  dm_arbiter_if #(.AW(AW), .DW(DW)) bus ();

  dm_arbiter #(.AW(AW), .DW(DW), .MAX_BURST(MAX_BURST)) dut (
    .CLK (CLK),
    .RST (RST),
    .bus (bus.slave)
  );

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
  endtask

  // Data memory seen by the DUT, and the reference copy written by the model.
  logic [DW-1:0] dm_mem  [16];
  logic [DW-1:0] ref_mem [16];

  assign bus.DMRD = dm_mem[bus.DMA[3:0]];

  always @(posedge CLK) begin
    if (bus.DMWE) dm_mem[bus.DMA[3:0]] = bus.DMWD;
  end

  // Model: who owns the memory (-1 none), last port served, locked transfers already extended.
  int            m_owner = -1;
  bit            m_last  = 1'b1;
  int            m_run   = 0;
  int            p_owner = -1;
  bit            p_last  = 1'b1;
  int            p_run   = 0;
  bit            p_wr    = 1'b0;
  logic [3:0]    p_waddr = '0;
  logic [DW-1:0] p_wdata = '0;

  logic          e_ack0, e_ack1, e_we;
  logic [AW-1:0] e_a;
  logic [DW-1:0] e_wd, e_rd0, e_rd1;
  bit            g_req, g_lock, g_we, o_req;
  logic [AW-1:0] g_a;
  logic [DW-1:0] g_wd;

  always @(negedge CLK) begin
    if (!RST) begin
      p_owner = -1; p_last = 1'b1; p_run = 0; p_wr = 1'b0;
    end else begin
      e_ack0 = 0; e_ack1 = 0; e_we = 0; e_a = '0; e_wd = '0; e_rd0 = '0; e_rd1 = '0;
      g_req  = (m_owner == 1) ? bus.REQ1  : bus.REQ0;
      g_lock = (m_owner == 1) ? bus.LOCK1 : bus.LOCK0;
      g_we   = (m_owner == 1) ? bus.WE1   : bus.WE0;
      g_a    = (m_owner == 1) ? bus.A1    : bus.A0;
      g_wd   = (m_owner == 1) ? bus.WD1   : bus.WD0;
      o_req  = (m_owner == 1) ? bus.REQ0  : bus.REQ1;
      if (m_owner >= 0) begin
        e_a  = g_a;
        e_wd = g_wd;
        e_we = g_we & g_req;
        if (m_owner == 0) begin
          e_ack0 = g_req;
          e_rd0  = g_req ? ref_mem[g_a[3:0]] : '0;
        end else begin
          e_ack1 = g_req;
          e_rd1  = g_req ? ref_mem[g_a[3:0]] : '0;
        end
      end
      check("ACK0", bus.ACK0, e_ack0);
      check("ACK1", bus.ACK1, e_ack1);
      check("DMWE", bus.DMWE, e_we);
      check("DMA",  bus.DMA,  e_a);
      check("DMWD", bus.DMWD, e_wd);
      check("RD0",  bus.RD0,  e_rd0);
      check("RD1",  bus.RD1,  e_rd1);

      p_wr = e_we; p_waddr = e_a[3:0]; p_wdata = e_wd;
      p_last = m_last; p_owner = m_owner; p_run = 0;
      if (m_owner < 0) begin
        if (bus.REQ0 && bus.REQ1) p_owner = m_last ? 0 : 1;
        else if (bus.REQ0)        p_owner = 0;
        else if (bus.REQ1)        p_owner = 1;
      end else begin
        if (g_req) p_last = (m_owner == 1);
        if (g_lock && g_req && (m_run + 2 <= MAX_BURST)) p_run = m_run + 1;
        else if (o_req) p_owner = 1 - m_owner;
        else if (!g_req) p_owner = -1;
      end
    end
  end

  always @(posedge CLK or negedge RST) begin
    if (!RST) begin
      m_owner = -1; m_last = 1'b1; m_run = 0;
    end else begin
      m_owner = p_owner; m_last = p_last; m_run = p_run;
      if (p_wr) ref_mem[p_waddr] = p_wdata;
    end
  end

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic set0(input bit req, input bit lock, input bit we, input int a, input logic [DW-1:0] wd);
    bus.REQ0 = req; bus.LOCK0 = lock; bus.WE0 = we; bus.A0 = AW'(a); bus.WD0 = wd;
  endtask

  task automatic set1(input bit req, input bit lock, input bit we, input int a, input logic [DW-1:0] wd);
    bus.REQ1 = req; bus.LOCK1 = lock; bus.WE1 = we; bus.A1 = AW'(a); bus.WD1 = wd;
  endtask

  task automatic do_reset();
    tick();
    RST = 1'b0;
    tick();
    RST = 1'b1;
  endtask

  logic [9:0] a0_bits, a1_bits;

  initial begin
    for (int i = 0; i < 16; i++) begin
      dm_mem[i]  = DW'(i * 3 + 100);
      ref_mem[i] = DW'(i * 3 + 100);
    end
    dm_mem[0] = 17;  ref_mem[0] = 17;
    dm_mem[1] = 31;  ref_mem[1] = 31;
    dm_mem[3] = 32'hFFFF_FFFE; ref_mem[3] = 32'hFFFF_FFFE;
    set0(0, 0, 0, 0, '0);
    set1(0, 0, 0, 0, '0);

    // Reset state, then a single write followed by a read of the same word.
    tick(); tick();
    check("rst_ack0", bus.ACK0, 0);
    check("rst_dmwe", bus.DMWE, 0);
    check("rst_dma",  bus.DMA,  0);
    RST = 1'b1;
    set0(1, 0, 1, 5, 32'h2A);
    #2 check("s1_ack0_c0", bus.ACK0, 0);
    tick();
    #2;
    check("s1_ack0_c1", bus.ACK0, 1);
    check("s1_dmwe",    bus.DMWE, 1);
    check("s1_dma",     bus.DMA,  5);
    check("s1_dmwd",    bus.DMWD, 32'h2A);
    tick();
    bus.WE0 = 1'b0;
    #2;
    check("s1_rd_ack0", bus.ACK0, 1);
    check("s1_rd0",     bus.RD0,  32'h2A);
    tick();
    set0(0, 0, 0, 0, '0);
    tick(); tick();

    // Both reading without lock: strict alternation starting with port 0.
    do_reset();
    set0(1, 0, 0, 0, '0);
    set1(1, 0, 0, 1, '0);
    for (int i = 0; i < 6; i++) begin
      tick();
      #2;
      a0_bits[i] = bus.ACK0;
      a1_bits[i] = bus.ACK1;
      if (i == 0) check("s2_rd0", bus.RD0, 17);
      if (i == 1) check("s2_rd1", bus.RD1, 31);
    end
    check("s2_ack0_seq", a0_bits[5:0], 6'b010101);
    check("s2_ack1_seq", a1_bits[5:0], 6'b101010);
    set0(0, 0, 0, 0, '0);
    set1(0, 0, 0, 0, '0);
    tick(); tick();

    // Port 0 locked against port 1: four-transfer bursts with one port-1 slot between.
    do_reset();
    set0(1, 1, 0, 2, '0);
    set1(1, 0, 0, 4, '0);
    for (int i = 0; i < 10; i++) begin
      tick();
      #2;
      a0_bits[i] = bus.ACK0;
      a1_bits[i] = bus.ACK1;
    end
    check("s3_ack0_seq", a0_bits, 10'b0111101111);
    check("s3_ack1_seq", a1_bits, 10'b1000010000);
    set0(0, 0, 0, 0, '0);
    set1(0, 0, 0, 0, '0);
    tick(); tick();

    // Port 0 alone, no lock: unlimited back-to-back transfers.
    set0(1, 0, 0, 6, '0);
    for (int i = 0; i < 6; i++) begin
      tick();
      #2;
      a0_bits[i] = bus.ACK0;
      a1_bits[i] = bus.ACK1;
    end
    check("s4_ack0_run", a0_bits[5:0], 6'b111111);
    check("s4_ack1_run", a1_bits[5:0], 6'b000000);
    set0(0, 0, 0, 0, '0);
    tick(); tick();

    // Port 1 drops its write request while granted: nothing is acknowledged or written.
    set1(1, 0, 1, 3, 32'hFFFF);
    tick();
    set1(0, 0, 1, 3, 32'hFFFF);
    #2;
    check("s5_ack1", bus.ACK1, 0);
    check("s5_dmwe", bus.DMWE, 0);
    tick(); tick();
    check("s5_mem3", dm_mem[3], 32'hFFFF_FFFE);

    // Mid-cycle reset during a port-1 burst, then the first tie goes to port 0.
    set1(1, 1, 1, 7, 32'h55);
    tick();
    tick();
    #2 RST = 1'b0;
    #1;
    check("s6_ack1", bus.ACK1, 0);
    check("s6_dmwe", bus.DMWE, 0);
    check("s6_dma",  bus.DMA,  0);
    check("s6_dmwd", bus.DMWD, 0);
    set0(1, 0, 0, 8, '0);
    set1(1, 0, 0, 9, '0);
    tick(); tick();
    RST = 1'b1;
    tick();
    #2;
    check("s6_first0", bus.ACK0, 1);
    check("s6_first1", bus.ACK1, 0);
    tick();
    #2 check("s6_then1", bus.ACK1, 1);
    check("s6_mem7", dm_mem[7], 32'h55);

    // Random traffic checked cycle by cycle against the model.
    for (int i = 0; i < 3000; i++) begin
      tick();
      set0($urandom_range(3) != 0, $urandom_range(1) == 1, $urandom_range(1) == 1,
           int'($urandom_range(15)), DW'($urandom));
      set1($urandom_range(3) != 0, $urandom_range(1) == 1, $urandom_range(1) == 1,
           int'($urandom_range(15)), DW'($urandom));
    end
    set0(0, 0, 0, 0, '0);
    set1(0, 0, 0, 0, '0);
    tick(); tick();
    for (int i = 0; i < 16; i++) check("final_mem", dm_mem[i], ref_mem[i]);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/dm_arbiter.md
Name: dm_arbiter

Overview:
- Two-requester arbiter that shares the single-port data memory between the processor load/store path (port 0) and a DMA/loader engine (port 1).
- Sits directly in front of the data memory, driving its write-enable, address and write-data inputs, and returning its asynchronous read data.
- Uses round-robin arbitration with an optional bounded burst lock and zero-bubble hand-over between ports.

Parameters:
- AW, 32, address width (matches DM address input)
- DW, 32, data width
- MAX_BURST, 4, maximum consecutive locked transfers before the grant must be offered to the other port (must be >= 1)

Ports:
- CLK  input  1  system clock, rising edge
- RST  input  1  asynchronous reset, active-low (0 = reset)
- REQ0  input  1  port 0 transfer request; held with WE0/A0/WD0 stable until ACK0
- LOCK0  input  1  port 0 requests to keep the grant for the next transfer
- WE0  input  1  port 0 write (1) / read (0)
- A0  input  AW  port 0 address
- WD0  input  DW  port 0 write data
- ACK0  output  1  port 0 transfer completes this cycle
- RD0  output  DW  port 0 read data, valid while ACK0=1
- REQ1, LOCK1, WE1, A1, WD1, ACK1, RD1  same as port 0, for port 1
- DMWE  output  1  data-memory write enable
- DMA  output  AW  data-memory address
- DMWD  output  DW  data-memory write data
- DMRD  input  DW  data-memory read data (asynchronous)

Behaviour:
- State register values: IDLE, G0, G1. Supporting registers are LAST (last-granted port) and BCNT (burst count, width clog2(MAX_BURST)+1).
- Reset (RST=0, asynchronous, effective mid-cycle) sets state=IDLE, LAST=1, BCNT=0. It also forces all outputs to 0 immediately, and any in-flight transfer is abandoned.
- IDLE:
  - Outputs ACKx=0, RDx=0, DMWE=0, DMA=0, DMWD=0.
  - At the clock edge: only REQ0 -> G0; only REQ1 -> G1.
  - Both requesting -> grant the port != LAST (round-robin; port 0 wins the first tie after reset).
  - Neither requesting -> stay in IDLE.
- Gx, combinational:
  - DMA=Ax and DMWD=WDx.
  - DMWE=WEx & REQx.
  - ACKx=REQx.
  - RDx=DMRD when ACKx=1, else 0. The other port's ACK and RD are 0.
- Latency: a request is acknowledged one cycle after being sampled from IDLE. A read returns data in the same cycle as ACK. A write is committed to DM at the edge that ends the ACK cycle.
- One transfer completes per cycle while granted. A requester that holds REQ after ACK presents a new transfer.
- Gx transitions at the clock edge, evaluated in priority order:
  1. LOCKx & REQx & (BCNT < MAX_BURST-1) -> stay in Gx, BCNT+=1.
  2. Otherwise, if the other port's REQ=1 -> G(other), BCNT=0. There is no idle bubble.
  3. Otherwise, if REQx=1 -> stay in Gx, BCNT=0 (no contention, so unlimited back-to-back).
  4. Otherwise -> IDLE, BCNT=0.
- LAST is updated to x on every edge leaving or staying in Gx with a completed transfer.
- Protocol violation: if REQx drops while in Gx, ACKx=0, DMWE=0 and no write occurs. The FSM then follows the rules above (normally going to IDLE or the other port).
- Simultaneous REQ0 and REQ1 rising in IDLE are resolved by LAST only.
- LOCK on the non-granted port has no effect.
- MAX_BURST=1 means LOCK never extends a grant.

Test Plan:
- Reset, then REQ0=1, WE0=1, A0=5, WD0=0x2A for one transfer -> ACK0 high exactly 1 cycle after sampling, DMWE=1, DMA=5, DMWD=0x2A. A subsequent read of A0=5 returns RD0=0x2A with ACK0.
- REQ0 and REQ1 both held from IDLE, no LOCK, reads of A0=0 and A1=1 (DM preloaded with 17, 31) -> alternating ACK0, ACK1, ACK0, ... each cycle with no bubbles, starting with port 0; RD0=17, RD1=31.
- REQ0+LOCK0 held and REQ1 held, MAX_BURST=4 -> ACK0 for 4 consecutive cycles, then ACK1 for 1 cycle, then 4 more ACK0 cycles.
- REQ0 only, with LOCK0=0, for 6 cycles -> ACK0 on 6 consecutive cycles, state never passes through IDLE, port 1 never acknowledged.
- REQ1 write (A1=3, WD1=0xFFFF) granted, REQ1 dropped during the G1 cycle -> ACK1=0, DMWE=0, and DM[3] keeps its value (-2).
- RST driven low between edges during a port-1 burst -> ACK1, DMWE, DMA and DMWD go to 0 immediately. After release with both REQs high, port 0 is granted first.
